// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit: multi-cycle radix-2 unsigned multiplier with HI/LO registers; optional MULTU_EARLY_EXIT_EN
module multu_hilo_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0]   acc, mcand, q;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;
    logic               last;
    // q starts as the multiplier and fills with low product bits as it shifts
    assign sum = {1'b0, acc} + (q[0] ? {1'b0, mcand} : '0);
`ifdef MULTU_EARLY_EXIT_EN
    logic [WIDTH-1:0] rem;
    // rem keeps only the multiplier bits not yet consumed after this step
    assign rem  = (q >> 1) << (cnt + 1'b1);
    assign last = (rem == '0) || (cnt == CNT_W'(WIDTH - 1));
    assign prod = (2*WIDTH)'({sum, q} >> (WIDTH - int'(cnt)));
`else
    assign last = cnt == CNT_W'(WIDTH - 1);
    assign prod = {sum, q[WIDTH-1:1]};
`endif
    assign busy    = state == RUN;
    assign done    = state == DONE;
    assign stall   = busy | (start & ~busy);
    assign rd_data = rd_sel == 2'b01 ? hi : rd_sel == 2'b10 ? lo : '0;
    // next state: flush wins, RUN ends on last iteration, start accepted from IDLE or DONE
    always_comb begin
        state_nx = IDLE;
        state_nx = flush ? IDLE : state == RUN ? (last ? DONE : RUN) : start ? RUN : IDLE;
    end
    // state, datapath and HI/LO commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nx;
            if (!flush && state != RUN && start) begin
                mcand <= op_a;
                q     <= op_b;
                acc   <= '0;
                cnt   <= '0;
            end else if (!flush && state == RUN) begin
                acc <= sum[WIDTH:1];
                q   <= {sum[0], q[WIDTH-1:1]};
                cnt <= cnt + 1'b1;
                if (last) {hi, lo} <= prod;
            end
        end
    end
endmodule

// File: tb/tb_multu_hilo_unit.sv
// tb_multu_hilo_unit: directed checks of multu_hilo_unit
module tb_multu_hilo_unit;
    logic        clk = 0, rst = 0, start = 0, flush = 0;
    logic [31:0] op_a = 0, op_b = 0, rd_data, hi, lo;
    logic [1:0]  rd_sel = 0;
    logic        busy, done, stall;
    int          errs = 0, checks = 0;
`ifdef MULTU_EARLY_EXIT_EN
    localparam bit EE = 1;
`else
    localparam bit EE = 0;
`endif

    multu_hilo_unit dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush), .op_a(op_a), .op_b(op_b),
        .rd_sel(rd_sel), .rd_data(rd_data), .hi(hi), .lo(lo), .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, output int n);
        op_a = a;
        op_b = b;
        start = 1;
        tick();
        start = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        #3;
        checks++; if ({hi, lo} !== 64'h0) begin errs++; $display("FAIL reset_hilo got %h exp 0", {hi, lo}); end
        checks++; if ({busy, done, stall} !== 3'b000) begin errs++; $display("FAIL reset_flags got %b exp 000", {busy, done, stall}); end
        #8 rst = 1;
        tick();
    endtask

    task automatic test_basic;
        int n;
        op_a = 3; op_b = 5; start = 1; #1;
        checks++; if (stall !== 1'b1) begin errs++; $display("FAIL t1_stall_start got %b exp 1", stall); end
        tick();
        start = 0;
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (n !== (EE ? 3 : 32)) begin errs++; $display("FAIL t1_latency got %0d exp %0d", n, EE ? 3 : 32); end
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL t1_done got %b exp 1", done); end
        checks++; if ({hi, lo} !== 64'h0000_0000_0000_000F) begin errs++; $display("FAIL t1_prod got %h exp f", {hi, lo}); end
        checks++; if (stall !== 1'b0) begin errs++; $display("FAIL t1_stall_after got %b exp 0", stall); end
        tick();
        checks++; if (done !== 1'b0) begin errs++; $display("FAIL t1_done_pulse got %b exp 0", done); end
    endtask

    task automatic test_max_and_read;
        int n;
        op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1;
        tick();
        start = 0;
        tick(); tick();
        op_a = 32'h1234; op_b = 32'h5678; start = 1;
        tick();
        start = 0;
        n = 3;
        while (busy === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (n !== 32) begin errs++; $display("FAIL t2_latency got %0d exp 32", n); end
        checks++; if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin errs++; $display("FAIL t2_prod got %h exp fffffffe00000001", {hi, lo}); end
        rd_sel = 2'b01; #1;
        checks++; if (rd_data !== 32'hFFFF_FFFE) begin errs++; $display("FAIL t2_rd_hi got %h exp fffffffe", rd_data); end
        rd_sel = 2'b10; #1;
        checks++; if (rd_data !== 32'h0000_0001) begin errs++; $display("FAIL t2_rd_lo got %h exp 1", rd_data); end
        rd_sel = 2'b11; #1;
        checks++; if (rd_data !== 32'h0) begin errs++; $display("FAIL t2_rd_11 got %h exp 0", rd_data); end
        rd_sel = 2'b00; #1;
        checks++; if (rd_data !== 32'h0) begin errs++; $display("FAIL t2_rd_00 got %h exp 0", rd_data); end
        tick();
    endtask

    task automatic test_flush;
        int n;
        run_mul(32'd2, 32'h8000_0001, n);
        checks++; if ({hi, lo} !== 64'h0000_0001_0000_0002) begin errs++; $display("FAIL t3_prior got %h exp 100000002", {hi, lo}); end
        tick();
        op_a = 7; op_b = 9; start = 1;
        tick();
        start = 0;
        repeat (EE ? 2 : 9) tick();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL t3_busy_before got %b exp 1", busy); end
        flush = 1;
        tick();
        flush = 0;
        checks++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL t3_flush_state got %b exp 00", {busy, done}); end
        checks++; if ({hi, lo} !== 64'h0000_0001_0000_0002) begin errs++; $display("FAIL t3_hilo_kept got %h exp 100000002", {hi, lo}); end
        repeat (40) begin
            tick();
            checks++; if (done !== 1'b0) begin errs++; $display("FAIL t3_no_done got %b exp 0", done); end
        end
        start = 1; flush = 1;
        tick();
        start = 0; flush = 0;
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL t3_flush_start got %b exp 0", busy); end
    endtask

    task automatic test_async_reset;
        int n;
        op_a = 7; op_b = 9; start = 1;
        tick();
        start = 0;
        tick();
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL t4_busy_before got %b exp 1", busy); end
        #2 rst = 0;
        #1;
        checks++; if ({hi, lo} !== 64'h0) begin errs++; $display("FAIL t4_hilo_cleared got %h exp 0", {hi, lo}); end
        checks++; if (busy !== 1'b0) begin errs++; $display("FAIL t4_busy_cleared got %b exp 0", busy); end
        tick();
        rst = 1;
        tick();
        run_mul(32'd2, 32'd4, n);
        checks++; if ({hi, lo} !== 64'd8) begin errs++; $display("FAIL t4_restart got %h exp 8", {hi, lo}); end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        run_mul(32'd3, 32'd5, n);
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL t5_done1 got %b exp 1", done); end
        checks++; if (lo !== 32'd15) begin errs++; $display("FAIL t5_lo1 got %0d exp 15", lo); end
        op_a = 6; op_b = 7; start = 1; #1;
        checks++; if (stall !== 1'b1) begin errs++; $display("FAIL t5_stall got %b exp 1", stall); end
        tick();
        start = 0;
        checks++; if (busy !== 1'b1) begin errs++; $display("FAIL t5_no_gap got %b exp 1", busy); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin n++; tick(); end
        checks++; if (done !== 1'b1) begin errs++; $display("FAIL t5_done2 got %b exp 1", done); end
        checks++; if ({hi, lo} !== 64'd42) begin errs++; $display("FAIL t5_lo2 got %h exp 42", {hi, lo}); end
        tick();
    endtask

    task automatic test_edge_operands;
        int n;
        run_mul(32'hDEAD_BEEF, 32'd1, n);
        checks++; if (n !== (EE ? 1 : 32)) begin errs++; $display("FAIL t6_b1_latency got %0d exp %0d", n, EE ? 1 : 32); end
        checks++; if ({hi, lo} !== 64'h0000_0000_DEAD_BEEF) begin errs++; $display("FAIL t6_b1_prod got %h exp deadbeef", {hi, lo}); end
        tick();
        run_mul(32'd3, 32'h8000_0000, n);
        checks++; if (n !== 32) begin errs++; $display("FAIL t6_bmsb_latency got %0d exp 32", n); end
        checks++; if ({hi, lo} !== 64'h0000_0001_8000_0000) begin errs++; $display("FAIL t6_bmsb_prod got %h exp 180000000", {hi, lo}); end
        tick();
        run_mul(32'h1234_5678, 32'd0, n);
        checks++; if (n !== (EE ? 1 : 32)) begin errs++; $display("FAIL t6_b0_latency got %0d exp %0d", n, EE ? 1 : 32); end
        checks++; if ({hi, lo} !== 64'h0) begin errs++; $display("FAIL t6_b0_prod got %h exp 0", {hi, lo}); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_and_read();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_edge_operands();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
